// File: rtl/ser_pkg.sv
// Shared constants and state encoding for the serial transmit path.
// Serializer-side blocks import this to agree on widths and FSM states.
package ser_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int SRC_W       = $clog2(NUM_REQ_DEF);
  localparam int CNT_W       = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans from last_grant+1 upward (wrapping)
// and returns the first eligible requester as one-hot plus index.
module rr_arbiter
  import ser_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant_i) + off) % NUM_REQ;
      if (!found && eligible_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ser_tx_scheduler.sv
// Shares one serial lane among NUM_REQ byte requesters, LSB first, with
// round-robin arbitration and back-to-back bytes when demand allows.
module ser_tx_scheduler
  import ser_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_en,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ser_data,
  output logic                      ser_frame,
  output logic [IDX_W-1:0]          ser_src,
  output logic                      busy,
  output logic [CNT_W-1:0]          byte_cnt
);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [CNT_W-1:0]    byte_cnt_q;
  logic [CNT_W-1:0]    byte_cnt_d;
  logic [IDX_W-1:0]    last_grant_q;
  logic [IDX_W-1:0]    src_q;
  logic                ser_data_q;
  logic                ser_frame_q;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                can_accept;
  logic                accept;
  logic [DATA_W-1:0]   win_byte;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .eligible_i   (req_valid & req_en),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  // A new byte may only be taken while idle or on the last bit of the current one.
  assign can_accept = rst_n && ((state_q == IDLE) || (bit_cnt_q == LAST_BIT));
  assign req_ready  = can_accept ? grant : '0;
  assign accept     = |req_ready;
  assign byte_cnt_d = byte_cnt_q + 1'b1;

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_byte = win_byte | req_data[i*DATA_W +: DATA_W];
    end
  end

  // Bit 0 is launched straight from the accepted byte so it appears one cycle after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      src_q        <= '0;
      ser_data_q   <= 1'b0;
      ser_frame_q  <= 1'b0;
    end else if (accept) begin
      state_q      <= SHIFT;
      shift_q      <= win_byte >> 1;
      ser_data_q   <= win_byte[0];
      ser_frame_q  <= 1'b1;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= byte_cnt_d;
      last_grant_q <= grant_idx;
      src_q        <= grant_idx;
    end else if (state_q == SHIFT) begin
      if (bit_cnt_q == LAST_BIT) begin
        state_q     <= IDLE;
        ser_data_q  <= 1'b0;
        ser_frame_q <= 1'b0;
      end else begin
        ser_data_q <= shift_q[0];
        shift_q    <= shift_q >> 1;
        bit_cnt_q  <= bit_cnt_q + 1'b1;
      end
    end
  end

  assign ser_data  = ser_data_q;
  assign ser_frame = ser_frame_q;
  assign ser_src   = src_q;
  assign busy      = (state_q == SHIFT);
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Directed bench for ser_tx_scheduler: expected bytes are queued as stimulus is
// driven and popped as the serial lane delivers them.
module tb_ser_tx_scheduler;
  import ser_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_en;
  logic [3:0]  req_ready;
  logic        ser_data;
  logic        ser_frame;
  logic [1:0]  ser_src;
  logic        busy;
  logic [15:0] byte_cnt;

  typedef struct {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ser_tx_scheduler #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_en    (req_en),
    .req_ready (req_ready),
    .ser_data  (ser_data),
    .ser_frame (ser_frame),
    .ser_src   (ser_src),
    .busy      (busy),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] en, input logic [31:0] data);
    req_valid = valid;
    req_en    = en;
    req_data  = data;
    #1;
  endtask

  task automatic pushExp(input logic [1:0] src, input logic [7:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    sb.push_back(e);
  endtask

  // Called on the cycle carrying bit 0; returns on the cycle after bit 7.
  task automatic receiveByte(input string tag);
    exp_t       e;
    logic [7:0] got;
    logic [1:0] firstSrc;
    logic       frameOk;
    logic       srcStable;
    checkOutput({tag, "_sbNonEmpty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e         = sb.pop_front();
    got       = '0;
    frameOk   = 1'b1;
    srcStable = 1'b1;
    firstSrc  = ser_src;
    for (int k = 0; k < 8; k++) begin
      if (ser_frame !== 1'b1) frameOk = 1'b0;
      if (ser_src !== firstSrc) srcStable = 1'b0;
      got[k] = ser_data;
      tick();
    end
    checkOutput({tag, "_frame"}, 32'(frameOk), 32'd1);
    checkOutput({tag, "_srcStable"}, 32'(srcStable), 32'd1);
    checkOutput({tag, "_src"}, 32'(firstSrc), 32'(e.src));
    checkOutput({tag, "_data"}, 32'(got), 32'(e.data));
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    applyStimulus(4'hF, 4'hF, 32'h44332211);
    checkOutput({tag, "_readyInReset"}, 32'(req_ready), 32'd0);
    tick();
    tick();
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_frame"}, 32'(ser_frame), 32'd0);
    checkOutput({tag, "_data"}, 32'(ser_data), 32'd0);
    checkOutput({tag, "_src"}, 32'(ser_src), 32'd0);
    checkOutput({tag, "_byteCnt"}, 32'(byte_cnt), 32'd0);
    checkOutput({tag, "_readyHeld"}, 32'(req_ready), 32'd0);
    applyStimulus(4'h0, 4'h0, 32'h0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [7:0] got;
    rst_n     = 1'b0;
    req_valid = '0;
    req_en    = '0;
    req_data  = '0;

    $display("[TB] single byte");
    doReset("rst1");
    tick();
    applyStimulus(4'b0001, 4'hF, 32'h000000A5);
    checkOutput("s1_ready", 32'(req_ready), 32'b0001);
    pushExp(2'd0, 8'hA5);
    tick();
    applyStimulus(4'b0000, 4'hF, 32'h0);
    receiveByte("s1");
    checkOutput("s1_idleFrame", 32'(ser_frame), 32'd0);
    checkOutput("s1_idleData", 32'(ser_data), 32'd0);
    checkOutput("s1_idleBusy", 32'(busy), 32'd0);
    checkOutput("s1_byteCnt", 32'(byte_cnt), 32'd1);

    $display("[TB] four requesters continuous");
    doReset("rst2");
    tick();
    applyStimulus(4'hF, 4'hF, 32'h44332211);
    pushExp(2'd0, 8'h11);
    pushExp(2'd1, 8'h22);
    pushExp(2'd2, 8'h33);
    pushExp(2'd3, 8'h44);
    pushExp(2'd0, 8'h11);
    tick();
    for (int b = 0; b < 4; b++) receiveByte($sformatf("s2_b%0d", b));
    applyStimulus(4'hF, 4'h0, 32'h44332211);
    receiveByte("s2_b4");
    checkOutput("s2_idleFrame", 32'(ser_frame), 32'd0);
    checkOutput("s2_idleBusy", 32'(busy), 32'd0);
    checkOutput("s2_byteCnt", 32'(byte_cnt), 32'd5);

    $display("[TB] enable mask");
    doReset("rst3");
    tick();
    applyStimulus(4'hF, 4'b1011, 32'h44332211);
    pushExp(2'd0, 8'h11);
    pushExp(2'd1, 8'h22);
    pushExp(2'd3, 8'h44);
    pushExp(2'd0, 8'h11);
    tick();
    for (int b = 0; b < 3; b++) receiveByte($sformatf("s3_b%0d", b));
    applyStimulus(4'hF, 4'h0, 32'h44332211);
    receiveByte("s3_b3");
    checkOutput("s3_idleBusy", 32'(busy), 32'd0);
    checkOutput("s3_byteCnt", 32'(byte_cnt), 32'd4);

    $display("[TB] valid rising mid-byte");
    doReset("rst4");
    tick();
    applyStimulus(4'b0001, 4'hF, 32'h0000005A);
    checkOutput("s4_ready0", 32'(req_ready), 32'b0001);
    tick();
    applyStimulus(4'b0000, 4'hF, 32'h00003C00);
    got = '0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) applyStimulus(4'b0010, 4'hF, 32'h00003C00);
      if (k >= 3) checkOutput($sformatf("s4_ready_b%0d", k), 32'(req_ready), (k == 7) ? 32'b0010 : 32'b0000);
      got[k] = ser_data;
      tick();
    end
    checkOutput("s4_r0Data", 32'(got), 32'h5A);
    pushExp(2'd1, 8'h3C);
    applyStimulus(4'b0000, 4'hF, 32'h0);
    receiveByte("s4_r1");
    checkOutput("s4_idleBusy", 32'(busy), 32'd0);
    checkOutput("s4_byteCnt", 32'(byte_cnt), 32'd2);

    $display("[TB] reset mid-byte");
    doReset("rst5");
    tick();
    applyStimulus(4'b0001, 4'hF, 32'h000000FF);
    tick();
    applyStimulus(4'b0000, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("s5_frameAtBit4", 32'(ser_frame), 32'd1);
    checkOutput("s5_countedInFlight", 32'(byte_cnt), 32'd1);
    rst_n = 1'b0;
    applyStimulus(4'b0110, 4'hF, 32'h44332211);
    checkOutput("s5_readyInReset", 32'(req_ready), 32'd0);
    tick();
    checkOutput("s5_frame", 32'(ser_frame), 32'd0);
    checkOutput("s5_data", 32'(ser_data), 32'd0);
    checkOutput("s5_busy", 32'(busy), 32'd0);
    checkOutput("s5_byteCnt", 32'(byte_cnt), 32'd0);
    checkOutput("s5_readyIdleReset", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    applyStimulus(4'hF, 4'hF, 32'h44332211);
    checkOutput("s5_nextGrant", 32'(req_ready), 32'b0001);
    pushExp(2'd0, 8'h11);
    tick();
    applyStimulus(4'h0, 4'h0, 32'h0);
    receiveByte("s5_after");
    checkOutput("s5_idleBusy", 32'(busy), 32'd0);

    $display("[TB] counter wrap");
    force dut.byte_cnt_q = 16'hFFFF;
    #1;
    release dut.byte_cnt_q;
    checkOutput("s6_preload", 32'(byte_cnt), 32'hFFFF);
    applyStimulus(4'b0001, 4'hF, 32'h00000077);
    checkOutput("s6_ready", 32'(req_ready), 32'b0001);
    pushExp(2'd0, 8'h77);
    tick();
    applyStimulus(4'h0, 4'hF, 32'h0);
    checkOutput("s6_wrap", 32'(byte_cnt), 32'd0);
    receiveByte("s6");
    checkOutput("s6_sbDrained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
